// File: rtl/ahb_slave_if.sv
// AHB slave front end of the AHB-to-APB bridge: address/data pipeline, peripheral decode, response.
// Optional: define AHB_SLV_ERRRESP_EN for a one-cycle ERROR response to out-of-map transfers.
module ahb_slave_if (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  output logic        valid,
  output logic [31:0] Haddr1,
  output logic [31:0] Haddr2,
  output logic [31:0] Hwdata1,
  output logic [31:0] Hwdata2,
  output logic        Hwritereg,
  output logic [2:0]  tempselx,
  output logic [31:0] Hrdata,
  output logic [1:0]  Hresp
);

  logic in_map;
  logic active;

  // Map is 0x8000_0000..0x8BFF_FFFF: top nibble 8, bits [27:26] pick one of three 64 MB slots.
  assign in_map = (Haddr[31:28] == 4'h8) && (Haddr[27:26] != 2'b11);
  assign active = Hreadyin && Htrans[1];
  assign valid  = active && in_map;

  always_comb begin
    tempselx = 3'b000;
    if (Haddr[31:28] == 4'h8) begin
      case (Haddr[27:26])
        2'b00:   tempselx = 3'b001;
        2'b01:   tempselx = 3'b010;
        2'b10:   tempselx = 3'b100;
        default: tempselx = 3'b000;
      endcase
    end
  end

  always_ff @(posedge Hclk or posedge Hresetn) begin
    if (Hresetn) begin
      Haddr1    <= 32'h0;
      Haddr2    <= 32'h0;
      Hwdata1   <= 32'h0;
      Hwdata2   <= 32'h0;
      Hwritereg <= 1'b0;
    end else begin
      Haddr1    <= Haddr;
      Haddr2    <= Haddr1;
      Hwdata1   <= Hwdata;
      Hwdata2   <= Hwdata1;
      Hwritereg <= Hwrite;
    end
  end

  // APB read data is muxed onto the bus further up in the bridge.
  assign Hrdata = 32'h0;

`ifdef AHB_SLV_ERRRESP_EN
  logic err;

  always_ff @(posedge Hclk or posedge Hresetn) begin
    if (Hresetn) err <= 1'b0;
    else         err <= active && !in_map;
  end

  assign Hresp = err ? 2'b01 : 2'b00;
`else
  assign Hresp = 2'b00;
`endif

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed self-checking bench for ahb_slave_if (honours AHB_SLV_ERRRESP_EN when defined).
module tb_ahb_slave_if;

  logic        Hclk = 1'b0;
  logic        Hresetn, Hwrite, Hreadyin;
  logic [1:0]  Htrans;
  logic [31:0] Haddr, Hwdata;
  logic        valid, Hwritereg;
  logic [31:0] Haddr1, Haddr2, Hwdata1, Hwdata2, Hrdata;
  logic [2:0]  tempselx;
  logic [1:0]  Hresp;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] sw_addr [7];
  logic [2:0]  sw_sel  [7];
  logic        sw_vld  [7];
  logic [1:0]  err_exp;

  ahb_slave_if dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
    .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata), .valid(valid),
    .Haddr1(Haddr1), .Haddr2(Haddr2), .Hwdata1(Hwdata1), .Hwdata2(Hwdata2),
    .Hwritereg(Hwritereg), .tempselx(tempselx), .Hrdata(Hrdata), .Hresp(Hresp)
  );

  always #5 Hclk = ~Hclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge Hclk);
    #1;
  endtask

  initial begin
    Hresetn = 1'b1; Hwrite = 1'b0; Hreadyin = 1'b0; Htrans = 2'b00;
    Haddr = 32'h0; Hwdata = 32'h0;
    `ifdef AHB_SLV_ERRRESP_EN err_exp = 2'b01; `else err_exp = 2'b00; `endif

    // reset state
    repeat (2) edge_step();
    check("rst_haddr1", Haddr1, 32'h0);
    check("rst_hwdata2", Hwdata2, 32'h0);
    check("rst_hwritereg", {31'h0, Hwritereg}, 32'h0);
    check("rst_hrdata", Hrdata, 32'h0);
    check("rst_hresp", {30'h0, Hresp}, 32'h0);
    @(negedge Hclk) Hresetn = 1'b0;

    // load nonzero pipeline contents, then async reset mid-cycle
    Haddr = 32'h1111_0000; Hwdata = 32'hAAAA_0001; Hwrite = 1'b1;
    edge_step();
    Haddr = 32'h2222_0000; Hwdata = 32'hBBBB_0002;
    edge_step();
    check("pre_haddr2", Haddr2, 32'h1111_0000);
    check("pre_hwdata1", Hwdata1, 32'hBBBB_0002);
    check("pre_hwritereg", {31'h0, Hwritereg}, 32'h1);
    #2 Hresetn = 1'b1;
    #1;
    check("async_haddr1", Haddr1, 32'h0);
    check("async_haddr2", Haddr2, 32'h0);
    check("async_hwdata1", Hwdata1, 32'h0);
    check("async_hwdata2", Hwdata2, 32'h0);
    check("async_hwritereg", {31'h0, Hwritereg}, 32'h0);
    @(negedge Hclk) Hresetn = 1'b0;

    // out-of-range NONSEQ
    Hwrite = 1'b0; Hreadyin = 1'b1; Htrans = 2'b10;
    Haddr = 32'h8C00_1234; Hwdata = 32'h8500_0000;
    #1;
    check("oor_valid", {31'h0, valid}, 32'h0);
    check("oor_sel", {29'h0, tempselx}, 32'h0);
    edge_step();
    check("oor_haddr1", Haddr1, 32'h8C00_1234);
    check("oor_hwdata1", Hwdata1, 32'h8500_0000);
    check("oor_hresp", {30'h0, Hresp}, {30'h0, err_exp});

    // Hreadyin low: no valid, decode still live, pipeline still captures
    @(negedge Hclk);
    Hreadyin = 1'b0; Htrans = 2'b11; Haddr = 32'h8040_0000; Hwdata = 32'h0000_00C3;
    #1;
    check("nrdy_valid", {31'h0, valid}, 32'h0);
    check("nrdy_sel", {29'h0, tempselx}, 32'h1);
    edge_step();
    check("oor_haddr2", Haddr2, 32'h8C00_1234);
    check("oor_hwdata2", Hwdata2, 32'h8500_0000);
    check("nrdy_haddr1", Haddr1, 32'h8040_0000);
    check("nrdy_hresp", {30'h0, Hresp}, 32'h0);

    // decode sweep across region boundaries
    sw_addr[0] = 32'h8000_0000; sw_sel[0] = 3'b001; sw_vld[0] = 1'b1;
    sw_addr[1] = 32'h83FF_FFFF; sw_sel[1] = 3'b001; sw_vld[1] = 1'b1;
    sw_addr[2] = 32'h8400_0000; sw_sel[2] = 3'b010; sw_vld[2] = 1'b1;
    sw_addr[3] = 32'h87FF_FFFF; sw_sel[3] = 3'b010; sw_vld[3] = 1'b1;
    sw_addr[4] = 32'h8800_0000; sw_sel[4] = 3'b100; sw_vld[4] = 1'b1;
    sw_addr[5] = 32'h8BFF_FFFF; sw_sel[5] = 3'b100; sw_vld[5] = 1'b1;
    sw_addr[6] = 32'h7FFF_FFFF; sw_sel[6] = 3'b000; sw_vld[6] = 1'b0;
    @(negedge Hclk);
    Hreadyin = 1'b1; Htrans = 2'b10;
    for (int i = 0; i < 7; i++) begin
      Haddr = sw_addr[i];
      #1;
      check($sformatf("sweep_sel_%0d", i), {29'h0, tempselx}, {29'h0, sw_sel[i]});
      check($sformatf("sweep_vld_%0d", i), {31'h0, valid}, {31'h0, sw_vld[i]});
    end

    // transfer types
    Haddr = 32'h8400_0010;
    for (int t = 0; t < 4; t++) begin
      Htrans = t[1:0];
      #1;
      check($sformatf("trans_vld_%0d", t), {31'h0, valid}, {31'h0, t[1]});
      check($sformatf("trans_sel_%0d", t), {29'h0, tempselx}, 32'h2);
    end

    // write direction follows one cycle later
    @(negedge Hclk);
    Htrans = 2'b00; Hwrite = 1'b1;
    #1;
    check("wr_before", {31'h0, Hwritereg}, 32'h0);
    edge_step();
    check("wr_hi", {31'h0, Hwritereg}, 32'h1);
    @(negedge Hclk) Hwrite = 1'b0;
    edge_step();
    check("wr_lo", {31'h0, Hwritereg}, 32'h0);
    check("end_hrdata", Hrdata, 32'h0);
    check("end_hresp", {30'h0, Hresp}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_slave_if.md
Name: ahb_slave_if

Overview:
- AHB-side slave front end of the AHB-to-APB bridge.
- Registers the AHB address, write data and write direction through a two-stage pipeline.
- Decodes the address into a one-hot peripheral select and flags valid transfers for the bridge FSM.
- Returns a fixed AHB response; read data is returned as zero.

Parameters:
- None. Address map, widths and number of selects are fixed as below.

Ports:
- Hclk      input   1   system clock, all flops on rising edge
- Hresetn   input   1   asynchronous reset, active-high; the port keeps the codebase name despite the suffix
- Hwrite    input   1   AHB transfer direction, 1 = write
- Hreadyin  input   1   AHB HREADY from the bus
- Htrans    input   2   AHB transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- Haddr     input   32  AHB address
- Hwdata    input   32  AHB write data
- valid     output  1   current bus cycle is a valid transfer to this bridge
- Haddr1    output  32  Haddr delayed 1 cycle
- Haddr2    output  32  Haddr delayed 2 cycles
- Hwdata1   output  32  Hwdata delayed 1 cycle
- Hwdata2   output  32  Hwdata delayed 2 cycles
- Hwritereg output  1   Hwrite delayed 1 cycle
- tempselx  output  3   one-hot peripheral select decoded from current Haddr
- Hrdata    output  32  read data to AHB
- Hresp     output  2   AHB response

Behaviour:
- Reset is asynchronous: Hresetn=1 immediately forces Haddr1, Haddr2, Hwdata1, Hwdata2 = 32'h0 and Hwritereg = 0. Registers hold these values while reset is asserted.
- Pipeline, on every rising Hclk out of reset, unconditionally (no enable, no dependence on Hreadyin/Htrans):
  - Haddr1 <= Haddr; Haddr2 <= Haddr1
  - Hwdata1 <= Hwdata; Hwdata2 <= Hwdata1
  - Hwritereg <= Hwrite
- Pipeline latency: Haddr1/Hwdata1/Hwritereg = 1 cycle; Haddr2/Hwdata2 = 2 cycles.
- Address decode (combinational, from current Haddr, independent of Htrans/Hreadyin/reset):
  - 32'h8000_0000..32'h83FF_FFFF -> tempselx = 3'b001
  - 32'h8400_0000..32'h87FF_FFFF -> tempselx = 3'b010
  - 32'h8800_0000..32'h8BFF_FFFF -> tempselx = 3'b100
  - Any other address (including >= 32'h8C00_0000 and < 32'h8000_0000) -> tempselx = 3'b000
  - Range boundaries are inclusive of the low bound and exclusive of the next region start.
- valid (combinational) = Hreadyin AND (Htrans == 10 or 11) AND (32'h8000_0000 <= Haddr < 32'h8C00_0000).
  - IDLE and BUSY never produce valid.
  - valid is not gated by reset.
- Hrdata = 32'h0 constant; APB read data is muxed elsewhere in the bridge.
- Hresp = 2'b00 (OKAY) constant when the optional feature is absent.
- No state machine in this block; the bridge FSM consumes valid/tempselx/pipeline outputs.

Optional Feature:
- Macro: AHB_SLV_ERRRESP_EN
- Defined:
  - Adds a registered error flag, reset to 0 asynchronously.
  - On a rising edge with Hreadyin=1, Htrans in {10,11} and Haddr outside 32'h8000_0000..32'h8BFF_FFFF, the flag sets for exactly one cycle; otherwise it clears.
  - Hresp = 2'b01 (ERROR) while the flag is set, else 2'b00.
  - valid and tempselx are unchanged.
- Not defined:
  - Hresp is constant 2'b00 and no extra flop exists.

Test Plan:
- Reset: assert Hresetn=1 mid-cycle with nonzero pipeline contents -> Haddr1/2, Hwdata1/2 = 0 and Hwritereg = 0 immediately, without waiting for a clock edge.
- Out-of-range NONSEQ: Hreadyin=1, Htrans=10, Haddr=32'h8C00_1234, Hwdata=32'h8500_0000 -> valid=0, tempselx=000. Next edge: Haddr1=32'h8C00_1234, Hwdata1=32'h8500_0000. Edge after that: Haddr2=32'h8C00_1234, Hwdata2=32'h8500_0000. With AHB_SLV_ERRRESP_EN: Hresp=01 for one cycle after the edge.
- Hreadyin low: Hreadyin=0, Htrans=11, Haddr=32'h8040_0000 -> valid=0, tempselx=001. Pipeline still captures Haddr1=32'h8040_0000 on the next edge.
- Decode sweep with Hreadyin=1, Htrans=10: Haddr = 32'h8000_0000, 83FF_FFFF, 8400_0000, 87FF_FFFF, 8800_0000, 8BFF_FFFF, 7FFF_FFFF -> tempselx = 001, 001, 010, 010, 100, 100, 000; valid = 1, 1, 1, 1, 1, 1, 0.
- Transfer types: Haddr=32'h8400_0010, Hreadyin=1, Htrans = 00/01/10/11 -> valid = 0/0/1/1, tempselx=010 in all four cases.
- Write direction: drive Hwrite=1 then 0 on consecutive cycles -> Hwritereg follows one cycle later. Hrdata=0 and Hresp=00 throughout (feature off).
